// File: rtl/sump_cmd_parser.sv
// sump_cmd_parser: frames SUMP UART bytes into short/long commands, emits argument word and one-cycle strobes
module sump_cmd_parser #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_data_i,
    output logic [31:0] cmd_o,
    output logic [3:0]  set_mask_o,
    output logic [3:0]  set_val_o,
    output logic [3:0]  set_cfg_o,
    output logic        arm_o,
    output logic        sft_rst_o,
    output logic        id_o,
    output logic        meta_o,
    output logic        set_div_o,
    output logic        set_cnt_o,
    output logic        set_flgs_o
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic {IDLE, ARGS} state_t;
    state_t        state;
    logic [1:0]    arg_cnt;
    logic [7:0]    op_q;
    logic [TW-1:0] tmo_cnt;
    logic [23:0]   asm_q;
    logic          trig_op;
    assign trig_op = op_q[7:4] == 4'hC;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            arg_cnt    <= '0;
            op_q       <= '0;
            tmo_cnt    <= '0;
            asm_q      <= '0;
            cmd_o      <= '0;
            set_mask_o <= '0;
            set_val_o  <= '0;
            set_cfg_o  <= '0;
            arm_o      <= 1'b0;
            sft_rst_o  <= 1'b0;
            id_o       <= 1'b0;
            meta_o     <= 1'b0;
            set_div_o  <= 1'b0;
            set_cnt_o  <= 1'b0;
            set_flgs_o <= 1'b0;
        end else begin
            set_mask_o <= '0;
            set_val_o  <= '0;
            set_cfg_o  <= '0;
            arm_o      <= 1'b0;
            sft_rst_o  <= 1'b0;
            id_o       <= 1'b0;
            meta_o     <= 1'b0;
            set_div_o  <= 1'b0;
            set_cnt_o  <= 1'b0;
            set_flgs_o <= 1'b0;
            if (state == IDLE) begin
                if (rx_stb_i && rx_data_i[7]) begin
                    op_q    <= rx_data_i;
                    arg_cnt <= '0;
                    tmo_cnt <= '0;
                    state   <= ARGS;
                end else if (rx_stb_i) begin
                    sft_rst_o <= rx_data_i == 8'h00;
                    arm_o     <= rx_data_i == 8'h01;
                    id_o      <= rx_data_i == 8'h02;
                    meta_o    <= rx_data_i == 8'h04;
                end
            end else if (rx_stb_i) begin
                asm_q   <= {rx_data_i, asm_q[23:8]};
                arg_cnt <= arg_cnt + 2'd1;
                tmo_cnt <= '0;
                if (arg_cnt == 2'd3) begin
                    cmd_o      <= {rx_data_i, asm_q};
                    state      <= IDLE;
                    set_mask_o <= trig_op && op_q[1:0] == 2'd0 ? 4'b0001 << op_q[3:2] : 4'b0000;
                    set_val_o  <= trig_op && op_q[1:0] == 2'd1 ? 4'b0001 << op_q[3:2] : 4'b0000;
                    set_cfg_o  <= trig_op && op_q[1:0] == 2'd2 ? 4'b0001 << op_q[3:2] : 4'b0000;
                    set_div_o  <= op_q == 8'h80;
                    set_cnt_o  <= op_q == 8'h81;
                    set_flgs_o <= op_q == 8'h82;
                end
            end else if (TIMEOUT != 0 && tmo_cnt == TW'(TIMEOUT - 1)) begin
                state <= IDLE;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sump_cmd_parser.sv
// tb_sump_cmd_parser: table-driven byte sequences with a per-cycle scoreboard on strobes and cmd_o
module tb_sump_cmd_parser;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_stb_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic [31:0] cmd_o;
    logic [3:0]  set_mask_o, set_val_o, set_cfg_o;
    logic        arm_o, sft_rst_o, id_o, meta_o, set_div_o, set_cnt_o, set_flgs_o;

    sump_cmd_parser #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rx_stb_i(rx_stb_i), .rx_data_i(rx_data_i),
        .cmd_o(cmd_o), .set_mask_o(set_mask_o), .set_val_o(set_val_o), .set_cfg_o(set_cfg_o),
        .arm_o(arm_o), .sft_rst_o(sft_rst_o), .id_o(id_o), .meta_o(meta_o),
        .set_div_o(set_div_o), .set_cnt_o(set_cnt_o), .set_flgs_o(set_flgs_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [18:0] ARM = 19'h40, SFT = 19'h20, ID = 19'h10, META = 19'h08;
    localparam logic [18:0] DIV = 19'h04, CNT = 19'h02, FLGS = 19'h01, NONE = 19'h0;

    function automatic logic [18:0] mask(input int n); return 19'(1) << (15 + n); endfunction
    function automatic logic [18:0] val(input int n);  return 19'(1) << (11 + n); endfunction
    function automatic logic [18:0] cfg(input int n);  return 19'(1) << (7 + n);  endfunction

    typedef struct {
        logic [39:0] bytes;
        int          n;
        int          pre_last;
        int          tail;
        bit          chk;
        logic [18:0] stb;
        logic [31:0] cmd;
    } vec_t;

    typedef struct {
        int          due;
        logic [18:0] stb;
        logic [31:0] cmd;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rst_q = 1'b1;
    logic [31:0] hold = '0;
    logic [18:0] st, es;
    logic [31:0] ec;

    always @(posedge clk_i) begin
        cyc   <= cyc + 1;
        rst_q <= rst_i;
    end

    always @(negedge clk_i) begin
        st = {set_mask_o, set_val_o, set_cfg_o, arm_o, sft_rst_o, id_o, meta_o, set_div_o, set_cnt_o, set_flgs_o};
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_expect: due cycle %0d never matched, now cycle %0d", sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (rst_q) begin
            hold = '0;
            es = NONE;
            ec = '0;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            es = sb[0].stb;
            ec = sb[0].cmd;
            hold = sb[0].cmd;
            void'(sb.pop_front());
        end else begin
            es = NONE;
            ec = hold;
        end
        checks++;
        if ({st, cmd_o} !== {es, ec}) begin
            errors++;
            $display("FAIL cycle_%0d: strobes=%05h cmd_o=%08h, expected strobes=%05h cmd_o=%08h", cyc, st, cmd_o, es, ec);
        end
    end

    function automatic vec_t mk(input logic [39:0] b, input int n, input int pre, input int tail,
                                input bit chk, input logic [18:0] stb, input logic [31:0] cmd);
        vec_t v;
        v.bytes = b; v.n = n; v.pre_last = pre; v.tail = tail; v.chk = chk; v.stb = stb; v.cmd = cmd;
        return v;
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1) idle(v.pre_last);
            rx_stb_i  = 1'b1;
            rx_data_i = v.bytes[39 - 8 * i -: 8];
            if (i == v.n - 1 && v.chk) begin
                e.due = cyc + 1;
                e.stb = v.stb;
                e.cmd = v.cmd;
                sb.push_back(e);
            end
            @(posedge clk_i);
            #1;
            rx_stb_i = 1'b0;
        end
        idle(v.tail);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) tbl.push_back(mk(40'h0000000000, 1, 0, 2, 1, SFT, 32'h0));
        tbl.push_back(mk(40'hC078563412, 5, 0, 2, 1, mask(0), 32'h12345678));
        tbl.push_back(mk(40'hCA00010203, 5, 0, 0, 1, cfg(2), 32'h03020100));
        tbl.push_back(mk(40'h0100000000, 1, 0, 2, 1, ARM, 32'h03020100));
        tbl.push_back(mk(40'h81AABB0000, 3, 0, 16, 0, NONE, 32'h0));
        tbl.push_back(mk(40'h0200000000, 1, 0, 2, 1, ID, 32'h03020100));
        tbl.push_back(mk(40'h81AABBCCDD, 5, 15, 2, 1, CNT, 32'hDDCCBBAA));
        tbl.push_back(mk(40'hFF01020304, 5, 0, 0, 1, NONE, 32'h04030201));
        tbl.push_back(mk(40'h0400000000, 1, 0, 2, 1, META, 32'h04030201));
        tbl.push_back(mk(40'h1100000000, 1, 0, 0, 1, NONE, 32'h04030201));
        tbl.push_back(mk(40'h1300000000, 1, 0, 2, 1, NONE, 32'h04030201));
        tbl.push_back(mk(40'h80A1B2C3D4, 5, 0, 0, 1, DIV, 32'hD4C3B2A1));
        tbl.push_back(mk(40'h8255667788, 5, 0, 0, 1, FLGS, 32'h88776655));
        tbl.push_back(mk(40'hCDDEADBEEF, 5, 0, 1, 1, val(3), 32'hEFBEADDE));
        tbl.push_back(mk(40'hC344332211, 5, 0, 1, 1, NONE, 32'h11223344));
        tbl.push_back(mk(40'hC000000000, 5, 0, 0, 1, mask(0), 32'h00000000));
        tbl.push_back(mk(40'h0200000000, 1, 0, 2, 1, ID, 32'h00000000));
        tbl.push_back(mk(40'hC801020304, 5, 0, 1, 1, mask(2), 32'h04030201));

        idle(3);
        rst_i = 1'b0;
        idle(2);
        foreach (tbl[i]) send(tbl[i]);

        // reset lands after two argument bytes; the partial C1 must vanish
        send(mk(40'hC111220000, 3, 0, 0, 0, NONE, 32'h0));
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        send(mk(40'hC511223344, 5, 0, 3, 1, val(1), 32'h44332211));

        // timeout expiring just after the opcode, then a short command decodes normally
        send(mk(40'h8000000000, 1, 0, 16, 0, NONE, 32'h0));
        send(mk(40'h0100000000, 1, 0, 3, 1, ARM, 32'h44332211));

        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
